// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and the pixel-colour stage.
// The generator (master) consumes the pixel-rate enable and produces counts, syncs and qualifiers.
`timescale 1ns/1ps
interface vga_timing_gen_if;
    logic        pix_en;
    logic [10:0] count_rgb;
    logic [9:0]  reset_count_rgb;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        line_end;
    logic        frame_start;

    modport master (
        input  pix_en,
        output count_rgb, reset_count_rgb, hsync, vsync, video_on, line_end, frame_start
    );

    modport slave (
        output pix_en,
        input  count_rgb, reset_count_rgb, hsync, vsync, video_on, line_end, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters plus registered sync and
// qualifier decodes. Decodes are computed from the next counter values so every output
// changes on the same clk edge as the counts. H_TOTAL must be <= 2048, V_TOTAL <= 1024.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 800,
    parameter int unsigned H_FP      = 56,
    parameter int unsigned H_SYNC    = 120,
    parameter int unsigned H_BP      = 64,
    parameter int unsigned V_VISIBLE = 600,
    parameter int unsigned V_FP      = 37,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BP      = 23,
    parameter bit          SYNC_POL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Terminal counts in counter width; window bounds one bit wider so an end
    // bound equal to 2048/1024 cannot alias to zero.
    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_END    = 12'(H_VISIBLE);
    localparam logic [11:0] H_SYNC_START = 12'(H_VISIBLE + H_FP);
    localparam logic [11:0] H_SYNC_END   = 12'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [10:0] h_next;
    logic [9:0]  v_next;
    logic [11:0] h_ext;
    logic [10:0] v_ext;

    logic        started;
    logic        decode_en;
    logic        hsync_q,  vsync_q,  video_on_q,  line_end_q,  frame_start_q;
    logic        hsync_d,  vsync_d,  video_on_d,  line_end_d,  frame_start_d;

    // Next raster position: h wraps at the end of a line and carries into v, which wraps at frame end.
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_next = h_cnt + 11'd1;
        end
    end

    assign h_ext     = {1'b0, h_next};
    assign v_ext     = {1'b0, v_next};
    assign decode_en = started | vif.pix_en;

    // Decode syncs and qualifiers from the next position; until the first advance they stay at reset values.
    always_comb begin
        hsync_d       = ~SYNC_POL;
        vsync_d       = ~SYNC_POL;
        video_on_d    = 1'b0;
        line_end_d    = 1'b0;
        frame_start_d = 1'b0;
        if (decode_en) begin
            hsync_d       = (h_ext >= H_SYNC_START && h_ext < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = (v_ext >= V_SYNC_START && v_ext < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            video_on_d    = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
            line_end_d    = (h_next == H_LAST);
            frame_start_d = (h_next == 11'd0) && (v_next == 10'd0);
        end
    end

    // Counters, started flag and decoded outputs all advance together on a pixel-enable cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            started       <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (vif.pix_en) begin
            h_cnt         <= h_next;
            v_cnt         <= v_next;
            started       <= 1'b1;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.count_rgb       = h_cnt;
    assign vif.reset_count_rgb = v_cnt;
    assign vif.hsync           = hsync_q;
    assign vif.vsync           = vsync_q;
    assign vif.video_on        = video_on_q;
    assign vif.line_end        = line_end_q;
    assign vif.frame_start     = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x600 instance and a tiny active-low-sync instance
// (15x8 raster) so frame wrap and mid-frame reset fit in a short run. Expected outputs come
// from the number of enabled advances since reset, turned into (h, v) by division.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        le;
        logic        fs;
    } outs_t;

    typedef struct {
        bit en;
        int h;
        int v;
        bit hs;
        bit vs;
        bit vo;
        bit le;
        bit fs;
    } vec_t;

    logic clk;
    logic rst_n_a;
    logic rst_n_b;
    int   total;
    int   bad;
    longint n_a;
    longint n_b;

    vga_timing_gen_if ia();
    vga_timing_gen_if ib();

    vga_timing_gen u_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .vif   (ia)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL  (1'b0)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .vif   (ib)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: position after n advances is (n mod H_TOTAL, (n div H_TOTAL) mod V_TOTAL).
    function automatic outs_t model(input longint n,
                                    input int hv, input int hf, input int hsw, input int hb,
                                    input int vv, input int vf, input int vsw, input int vb,
                                    input bit pol);
        outs_t  o;
        longint ht, vt, h, v;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (n == 0) begin
            o = '{h: 11'd0, v: 10'd0, hs: ~pol, vs: ~pol, vo: 1'b0, le: 1'b0, fs: 1'b0};
        end else begin
            h    = n % ht;
            v    = (n / ht) % vt;
            o.h  = 11'(h);
            o.v  = 10'(v);
            o.hs = (h >= hv + hf && h < hv + hf + hsw) ? pol : ~pol;
            o.vs = (v >= vv + vf && v < vv + vf + vsw) ? pol : ~pol;
            o.vo = (h < hv) && (v < vv);
            o.le = (h == ht - 1);
            o.fs = (h == 0) && (v == 0);
        end
        return o;
    endfunction

    function automatic outs_t model_a(input longint n);
        return model(n, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1);
    endfunction

    function automatic outs_t model_b(input longint n);
        return model(n, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0);
    endfunction

    function automatic outs_t get_a();
        return '{h: ia.count_rgb, v: ia.reset_count_rgb, hs: ia.hsync, vs: ia.vsync,
                 vo: ia.video_on, le: ia.line_end, fs: ia.frame_start};
    endfunction

    function automatic outs_t get_b();
        return '{h: ib.count_rgb, v: ib.reset_count_rgb, hs: ib.hsync, vs: ib.vsync,
                 vo: ib.video_on, le: ib.line_end, fs: ib.frame_start};
    endfunction

    task automatic check_output(input string name, input outs_t act, input outs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got h=%0d v=%0d hs=%b vs=%b vo=%b le=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b vo=%b le=%b fs=%b",
                     name, act.h, act.v, act.hs, act.vs, act.vo, act.le, act.fs,
                     exp.h, exp.v, exp.hs, exp.vs, exp.vo, exp.le, exp.fs);
        end
    endtask

    task automatic check_value(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clk of instance A: drive pix_en away from the edge, sample 1 ns after it.
    task automatic apply_stimulus_a(input bit en);
        @(negedge clk);
        ia.pix_en = en;
        @(posedge clk);
        #1;
        ia.pix_en = 1'b0;
        if (en && rst_n_a) n_a++;
    endtask

    task automatic apply_stimulus_b(input bit en);
        @(negedge clk);
        ib.pix_en = en;
        @(posedge clk);
        #1;
        ib.pix_en = 1'b0;
        if (en && rst_n_b) n_b++;
    endtask

    vec_t  tbl[6];
    outs_t exp_o;
    int    hs_cnt, le_cnt, vo_off, vs_cnt, hsb_cnt;

    initial begin
        tbl[0] = '{en: 1'b0, h: 0, v: 0, hs: 1'b0, vs: 1'b0, vo: 1'b0, le: 1'b0, fs: 1'b0};
        tbl[1] = '{en: 1'b1, h: 1, v: 0, hs: 1'b0, vs: 1'b0, vo: 1'b1, le: 1'b0, fs: 1'b0};
        tbl[2] = '{en: 1'b0, h: 1, v: 0, hs: 1'b0, vs: 1'b0, vo: 1'b1, le: 1'b0, fs: 1'b0};
        tbl[3] = '{en: 1'b0, h: 1, v: 0, hs: 1'b0, vs: 1'b0, vo: 1'b1, le: 1'b0, fs: 1'b0};
        tbl[4] = '{en: 1'b1, h: 2, v: 0, hs: 1'b0, vs: 1'b0, vo: 1'b1, le: 1'b0, fs: 1'b0};
        tbl[5] = '{en: 1'b1, h: 3, v: 0, hs: 1'b0, vs: 1'b0, vo: 1'b1, le: 1'b0, fs: 1'b0};

        total    = 0;
        bad      = 0;
        n_a      = 0;
        n_b      = 0;
        ia.pix_en = 1'b1;
        ib.pix_en = 1'b0;
        rst_n_a  = 1'b0;
        rst_n_b  = 1'b0;

        // Reset held with pix_en high: nothing may advance.
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_hold_a", get_a(),
                     '{h: 11'd0, v: 10'd0, hs: 1'b0, vs: 1'b0, vo: 1'b0, le: 1'b0, fs: 1'b0});
        ia.pix_en = 1'b0;
        #2;
        rst_n_a = 1'b1;

        // Startup and pix_en gating vectors (1,0,0,1 gives an advance of 2).
        for (int i = 0; i < 6; i++) begin
            apply_stimulus_a(tbl[i].en);
            exp_o = '{h: 11'(tbl[i].h), v: 10'(tbl[i].v), hs: tbl[i].hs, vs: tbl[i].vs,
                      vo: tbl[i].vo, le: tbl[i].le, fs: tbl[i].fs};
            check_output($sformatf("vec%0d", i), get_a(), exp_o);
        end

        // Continuous run to the last pixel of line 5, tallying that line's decodes.
        hs_cnt = 0;
        le_cnt = 0;
        vo_off = 0;
        while (n_a < 6239) begin
            apply_stimulus_a(1'b1);
            check_output("run_a", get_a(), model_a(n_a));
            if (ia.reset_count_rgb == 10'd5) begin
                if (ia.hsync)     hs_cnt++;
                if (ia.line_end)  le_cnt++;
                if (!ia.video_on) vo_off++;
            end
        end
        check_output("line5_last", get_a(),
                     '{h: 11'd1039, v: 10'd5, hs: 1'b0, vs: 1'b0, vo: 1'b0, le: 1'b1, fs: 1'b0});
        check_value("hsync_cycles_line5", hs_cnt, 120);
        check_value("line_end_cycles_line5", le_cnt, 1);
        check_value("video_off_cycles_line5", vo_off, 240);
        apply_stimulus_a(1'b1);
        check_output("line_wrap", get_a(),
                     '{h: 11'd0, v: 10'd6, hs: 1'b0, vs: 1'b0, vo: 1'b1, le: 1'b0, fs: 1'b0});

        // Randomly gated pixel enable against the reference.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus_a($urandom_range(0, 3) != 0);
            check_output("rand_a", get_a(), model_a(n_a));
        end

        // Small raster, active-low syncs: reset values then random gating across several frames.
        #2;
        rst_n_b = 1'b1;
        apply_stimulus_b(1'b0);
        check_output("reset_b", get_b(),
                     '{h: 11'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b0, le: 1'b0, fs: 1'b0});
        for (int i = 0; i < 500; i++) begin
            apply_stimulus_b($urandom_range(0, 1) != 0);
            check_output("rand_b", get_b(), model_b(n_b));
        end

        // Frame wrap: run to (14,7), then one advance lands on (0,0) with frame_start.
        for (int i = 0; i < 200 && (n_b % 120) != 119; i++) apply_stimulus_b(1'b1);
        check_output("frame_last", get_b(),
                     '{h: 11'd14, v: 10'd7, hs: 1'b1, vs: 1'b1, vo: 1'b0, le: 1'b1, fs: 1'b0});
        apply_stimulus_b(1'b1);
        check_output("frame_wrap", get_b(),
                     '{h: 11'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b1, le: 1'b0, fs: 1'b1});
        apply_stimulus_b(1'b1);
        check_output("frame_next", get_b(),
                     '{h: 11'd1, v: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b1, le: 1'b0, fs: 1'b0});

        // One full frame: vsync low on lines 5..6, hsync low for h 10..12 on every line.
        vs_cnt  = 0;
        hsb_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            apply_stimulus_b(1'b1);
            if (!ib.vsync) vs_cnt++;
            if (!ib.hsync) hsb_cnt++;
        end
        check_value("vsync_cycles_frame_b", vs_cnt, 30);
        check_value("hsync_cycles_frame_b", hsb_cnt, 24);

        // Async reset mid-frame at (6,3), asserted between edges.
        for (int i = 0; i < 200 && (n_b % 120) != 51; i++) apply_stimulus_b(1'b1);
        check_output("pre_reset_b", get_b(), model_b(n_b));
        #2;
        rst_n_b = 1'b0;
        n_b     = 0;
        #1;
        check_output("async_reset_b", get_b(),
                     '{h: 11'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b0, le: 1'b0, fs: 1'b0});
        apply_stimulus_b(1'b1);
        check_output("reset_held_b", get_b(),
                     '{h: 11'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b0, le: 1'b0, fs: 1'b0});
        #2;
        rst_n_b = 1'b1;
        apply_stimulus_b(1'b1);
        check_output("restart_b", get_b(),
                     '{h: 11'd1, v: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b1, le: 1'b0, fs: 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
